serial_pp_accumulator: RTL and testbench

- Sequential radix-2 signed multiplier control and accumulation stage. It sits directly downstream of the binary partial-product generator and consumes its output.
- Captures operands X (multiplier) and Y (multiplicand), then issues one multiplier bit per cycle to the generator. It drives the generator's select bit and multiplicand, and receives the W+1-bit sign-extended partial product.
- Shifts and accumulates the partial products into a 2W-bit two's-complement product, delivered over a valid/ready handshake.

---
 rtl/serial_pp_accumulator.sv | 149 ++++++++++++++
 tb/tb_serial_pp_accumulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_pp_accumulator.sv
// Sequential radix-2 signed multiplier: issues one multiplier bit per cycle to a partial-product
// generator and shift-accumulates its result. Optional macro: SERIAL_PP_EARLY_TERM_EN.
module serial_pp_accumulator #(
    parameter int W      = 16,
    parameter int PP_LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           pp_bit,
    output logic [W-1:0]   pp_y,
    input  logic [W:0]     pp_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the producer holds
    // its data stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     pp_y_q, pp_y_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    idx_dly_q, idx_dly_d;
    logic             add_en_q, add_en_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic             pp_bit_q, pp_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             early_run;
    logic             acc_en;
    logic [IW-1:0]    acc_idx;

    // Weight a partial product by 2^i; the top bit of a signed multiplier carries negative weight.
    function automatic logic [2*W-1:0] weigh(input logic [W:0] pp, input logic [IW-1:0] i);
        logic [2*W-1:0] ext;
        ext = {{(W-1){pp[W]}}, pp};
        ext = ext << i;
        return (i == LAST) ? ((2*W)'(0) - ext) : ext;
    endfunction

`ifdef SERIAL_PP_EARLY_TERM_EN
    assign early_run = (state_q == RUN) && (x_q == '0);
`else
    assign early_run = 1'b0;
`endif

    // x_q is shifted right each issued bit, so x_q[0] is always the bit for the current index.
    assign acc_en  = (PP_LAT == 0) ? ((state_q == RUN) && !early_run) : add_en_q;
    assign acc_idx = (PP_LAT == 0) ? idx_q : idx_dly_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        pp_y_d      = pp_y_q;
        idx_d       = idx_q;
        idx_dly_d   = idx_q;
        add_en_d    = 1'b0;
        acc_d       = acc_q;
        pp_bit_d    = 1'b0;
        out_valid_d = out_valid_q;
        if (acc_en) begin
            acc_d = acc_q + weigh(pp_in, acc_idx);
        end
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d      = x;
                    pp_y_d   = y;
                    acc_d    = '0;
                    idx_d    = '0;
                    pp_bit_d = x[0];
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (early_run) begin
                    idx_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    add_en_d = 1'b1;
                    x_d      = x_q >> 1;
                    if (idx_q == LAST) begin
                        idx_d       = '0;
                        state_d     = (PP_LAT == 1) ? DRAIN : DONE;
                        out_valid_d = (PP_LAT == 0);
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        pp_bit_d = x_q[1];
                    end
                end
            end
            DRAIN: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            pp_y_q      <= '0;
            idx_q       <= '0;
            idx_dly_q   <= '0;
            add_en_q    <= 1'b0;
            acc_q       <= '0;
            pp_bit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            pp_y_q      <= pp_y_d;
            idx_q       <= idx_d;
            idx_dly_q   <= idx_dly_d;
            add_en_q    <= add_en_d;
            acc_q       <= acc_d;
            pp_bit_q    <= pp_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign pp_bit    = pp_bit_q;
    assign pp_y      = pp_y_q;
    assign out_valid = out_valid_q;
    assign product   = acc_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_serial_pp_accumulator.sv
// Directed-vector bench: one accumulator per partial-product latency, each fed by a
// behavioural radix-2 generator (combinational for PP_LAT=0, registered for PP_LAT=1).
module tb_serial_pp_accumulator;
  localparam int W = 16;

  logic clk, rst;
  logic in_valid, out_ready, sel;
  logic [W-1:0] x, y;

  logic in_ready0, pp_bit0, out_valid0, busy0;
  logic in_ready1, pp_bit1, out_valid1, busy1;
  logic [W-1:0] pp_y0, pp_y1;
  logic [W:0] pp_in0, pp_in1;
  logic [2*W-1:0] product0, product1;

  logic m_in_ready, m_pp_bit, m_out_valid, m_busy;
  logic [W-1:0] m_pp_y;
  logic [2*W-1:0] m_product;

  int cmp_n = 0;
  int fail_n = 0;
  logic [2*W-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // generator models
  assign pp_in0 = pp_bit0 ? {pp_y0[W-1], pp_y0} : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pp_in1 <= '0;
    else     pp_in1 <= pp_bit1 ? {pp_y1[W-1], pp_y1} : '0;
  end

  serial_pp_accumulator #(.W(W), .PP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
    .x(x), .y(y), .pp_bit(pp_bit0), .pp_y(pp_y0), .pp_in(pp_in0),
    .out_valid(out_valid0), .out_ready(out_ready), .product(product0), .busy(busy0)
  );

  serial_pp_accumulator #(.W(W), .PP_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready1),
    .x(x), .y(y), .pp_bit(pp_bit1), .pp_y(pp_y1), .pp_in(pp_in1),
    .out_valid(out_valid1), .out_ready(out_ready), .product(product1), .busy(busy1)
  );

  assign m_in_ready  = sel ? in_ready1  : in_ready0;
  assign m_pp_bit    = sel ? pp_bit1    : pp_bit0;
  assign m_out_valid = sel ? out_valid1 : out_valid0;
  assign m_busy      = sel ? busy1      : busy0;
  assign m_pp_y      = sel ? pp_y1      : pp_y0;
  assign m_product   = sel ? product1   : product0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected edges from the accepting edge to the first cycle with out_valid
  function automatic int lat_of(input logic [W-1:0] vx, input bit s);
`ifdef SERIAL_PP_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < W; i++) if (vx[i]) msb = i;
    if (msb < 0) return 1;
    if (msb == W - 1) return W + int'(s);
    return msb + 2;
`else
    return W + int'(s) + 0 * int'(vx[0]);
`endif
  endfunction

  // driver: one full operation, optionally stalling the output for 'hold' cycles
  task automatic run_op(input logic [W-1:0] vx, input logic [W-1:0] vy,
                        input logic [2*W-1:0] vp, input bit s, input int hold);
    int n;
    logic [2*W-1:0] exp_p;
    @(negedge clk);
    sel = s;
    out_ready = (hold == 0);
    #1;
    chk("in_ready_idle", m_in_ready, 1'b1);
    x = vx; y = vy; in_valid = 1'b1;
    exp_q.push_back(vp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = W'($urandom_range(0, 65535));
    y = W'($urandom_range(0, 65535));
    chk("busy_run", m_busy, 1'b1);
    chk("pp_y_cap", m_pp_y, vy);
    chk("pp_bit0", m_pp_bit, vx[0]);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!m_out_valid && n < 100);
    chk("latency", n, lat_of(vx, s));
    exp_p = exp_q.pop_front();
    chk("product", m_product, exp_p);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", m_out_valid, 1'b1);
      chk("hold_product", m_product, exp_p);
      chk("hold_in_ready", m_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_valid", m_out_valid, 1'b0);
    chk("post_in_ready", m_in_ready, 1'b1);
    chk("post_busy", m_busy, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0]   vx;
    logic [W-1:0]   vy;
    logic [2*W-1:0] prod;
    bit             s;
    int             hold;
  } vec_t;

  vec_t v[13];

  initial begin
    v[0]  = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0, 0};
    v[1]  = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 0};
    v[2]  = '{16'h8000, 16'h8000, 32'h40000000, 1'b0, 0};
    v[3]  = '{16'hFFFE, 16'h3039, 32'hFFFF9F8E, 1'b0, 10};
    v[4]  = '{16'h7FFF, 16'h8000, 32'hC0008000, 1'b0, 0};
    v[5]  = '{16'h0000, 16'h1234, 32'h00000000, 1'b0, 0};
    v[6]  = '{16'h8000, 16'hFFFF, 32'h00008000, 1'b0, 0};
    v[7]  = '{16'h0064, 16'hFFFD, 32'hFFFFFED4, 1'b0, 0};
    v[8]  = '{16'h0001, 16'h0009, 32'h00000009, 1'b0, 0};
    v[9]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1, 0};
    v[10] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1, 0};
    v[11] = '{16'h8000, 16'h8000, 32'h40000000, 1'b1, 0};
    v[12] = '{16'hFFFE, 16'h3039, 32'hFFFF9F8E, 1'b1, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0; x = '0; y = '0;
    #1;
    chk("rst_in_ready", in_ready0, 1'b0);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_pp_bit", pp_bit0, 1'b0);
    chk("rst_pp_y", pp_y0, '0);
    chk("rst_product", product0, '0);
    chk("rst_in_ready1", in_ready1, 1'b0);
    chk("rst_out_valid1", out_valid1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_op(v[i].vx, v[i].vy, v[i].prod, v[i].s, v[i].hold);

    // reset in the middle of RUN at index 7, after an ignored in_valid pulse while busy
    @(negedge clk);
    sel = 1'b0;
    x = 16'h0081; y = 16'h0003; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    x = 16'h1111; y = 16'h2222; in_valid = 1'b1;
    chk("busy_in_ready", m_in_ready, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ignored_pp_y", m_pp_y, 16'h0003);
    repeat (3) @(posedge clk);
    #1;
    chk("idx7_pp_bit", m_pp_bit, 1'b1);
    chk("idx7_busy", m_busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", m_in_ready, 1'b0);
    chk("abort_out_valid", m_out_valid, 1'b0);
    chk("abort_busy", m_busy, 1'b0);
    chk("abort_pp_bit", m_pp_bit, 1'b0);
    chk("abort_pp_y", m_pp_y, '0);
    chk("abort_product", m_product, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready", m_in_ready, 1'b1);
    run_op(16'h0002, 16'h0007, 32'h0000000E, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
